// File: rtl/cheshire_addr_map_unit.sv
// Programmable address map: NumRules {start,end,port,en} rules, lowest match wins.
// Optional sticky table lock via `define CHESHIRE_ADDRMAP_LOCK_EN.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   cfg_*               config req (valid/ready) -> 1-cycle response (rvalid/rdata/error)
//   lkp_*               lookup request (valid/ready, address)
//   res_*               registered lookup result (valid/ready, port/hit/rule)
//   lock_i              freeze request (honoured only with the lock macro)
//
// ResetMap entry layout: [136:129] port, [128:65] start, [64:1] end, [0] en.
module cheshire_addr_map_unit #(
  parameter int unsigned NumRules    = 8,
  parameter int unsigned NumPorts    = 6,
  parameter int unsigned AddrWidth   = 48,
  parameter int unsigned DefaultPort = 0,
  parameter logic [NumRules-1:0][136:0] ResetMap = '0,
  localparam int unsigned PW = (NumPorts > 1) ? $clog2(NumPorts) : 1,
  localparam int unsigned RW = (NumRules > 1) ? $clog2(NumRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic                 cfg_we_i,
  input  logic [RW-1:0]        cfg_rule_i,
  input  logic [1:0]           cfg_field_i,
  input  logic [63:0]          cfg_wdata_i,
  output logic                 cfg_rvalid_o,
  output logic [63:0]          cfg_rdata_o,
  output logic                 cfg_error_o,
  input  logic                 lkp_valid_i,
  output logic                 lkp_ready_o,
  input  logic [AddrWidth-1:0] lkp_addr_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [PW-1:0]        res_port_o,
  output logic                 res_hit_o,
  output logic [RW-1:0]        res_rule_o,
  input  logic                 lock_i
);

  localparam logic [PW-1:0] DefPort = PW'(DefaultPort);

  logic [AddrWidth-1:0] r_start [NumRules];
  logic [AddrWidth-1:0] r_end   [NumRules];
  logic [PW-1:0]        r_port  [NumRules];
  logic [NumRules-1:0]  r_en;

  logic                 r_cfg_rvalid;
  logic [63:0]          r_cfg_rdata;
  logic                 r_cfg_error;
  logic                 r_res_valid;
  logic [PW-1:0]        r_res_port;
  logic                 r_res_hit;
  logic [RW-1:0]        r_res_rule;

  logic                 w_cfg_acc;
  logic                 w_rule_ok;
  logic                 w_err;
  logic                 w_wr;
  logic                 w_locked;
  logic [PW-1:0]        w_wport;
  logic [PW-1:0]        w_wport_st;
  logic [63:0]          w_rdata;
  logic                 w_hit;
  logic [RW-1:0]        w_rule;
  logic [PW-1:0]        w_port;
  logic                 w_lkp_acc;

`ifdef CHESHIRE_ADDRMAP_LOCK_EN
  logic r_lock;

  always_ff @(posedge clk_i) begin
    if (rst_i)       r_lock <= 1'b0;
    else if (lock_i) r_lock <= 1'b1;
  end

  assign w_locked = r_lock;
  logic w_unused_wdata;
  assign w_unused_wdata = ^cfg_wdata_i;
`else
  assign w_locked = 1'b0;
  logic w_unused_in;
  assign w_unused_in = lock_i ^ (^cfg_wdata_i);
`endif

  // Response register drains every cycle, so a request is always accepted.
  assign cfg_ready_o = 1'b1;
  assign w_cfg_acc   = cfg_valid_i && cfg_ready_o;
  assign w_rule_ok   = 32'(cfg_rule_i) < NumRules;
  assign w_err       = !w_rule_ok || (cfg_field_i == 2'd3)
                     || (cfg_we_i && w_locked);
  assign w_wr        = w_cfg_acc && cfg_we_i && !w_err;

  assign w_wport    = cfg_wdata_i[8 +: PW];
  assign w_wport_st = (32'(w_wport) < NumPorts) ? w_wport : DefPort;

  always_comb begin
    w_rdata = '0;
    if (w_rule_ok) begin
      case (cfg_field_i)
        2'd0: w_rdata = 64'(r_start[cfg_rule_i]);
        2'd1: w_rdata = 64'(r_end[cfg_rule_i]);
        2'd2: begin
          w_rdata[0]       = r_en[cfg_rule_i];
          w_rdata[8 +: PW] = r_port[cfg_rule_i];
        end
        default: w_rdata = '0;
      endcase
    end
  end

  // Scan high to low so the lowest matching index is the final assignment.
  always_comb begin
    w_hit  = 1'b0;
    w_rule = '0;
    w_port = DefPort;
    for (int i = int'(NumRules) - 1; i >= 0; i--) begin
      if (r_en[i] && lkp_addr_i >= r_start[i]
          && lkp_addr_i < r_end[i]) begin
        w_hit  = 1'b1;
        w_rule = RW'(i);
        w_port = r_port[i];
      end
    end
  end

  assign lkp_ready_o = !r_res_valid || res_ready_i;
  assign w_lkp_acc   = lkp_valid_i && lkp_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NumRules); i++) begin
        r_en[i]    <= ResetMap[i][0];
        r_end[i]   <= ResetMap[i][1 +: AddrWidth];
        r_start[i] <= ResetMap[i][65 +: AddrWidth];
        r_port[i]  <= ResetMap[i][129 +: PW];
      end
      r_cfg_rvalid <= 1'b0;
      r_cfg_rdata  <= '0;
      r_cfg_error  <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_port   <= DefPort;
      r_res_hit    <= 1'b0;
      r_res_rule   <= '0;
    end else begin
      if (w_wr) begin
        case (cfg_field_i)
          2'd0: r_start[cfg_rule_i] <= cfg_wdata_i[AddrWidth-1:0];
          2'd1: r_end[cfg_rule_i]   <= cfg_wdata_i[AddrWidth-1:0];
          2'd2: begin
            r_en[cfg_rule_i]   <= cfg_wdata_i[0];
            r_port[cfg_rule_i] <= w_wport_st;
          end
          default: ;
        endcase
      end
      r_cfg_rvalid <= w_cfg_acc;
      r_cfg_rdata  <= (w_cfg_acc && !cfg_we_i) ? w_rdata : '0;
      r_cfg_error  <= w_cfg_acc && w_err;
      if (w_lkp_acc) begin
        r_res_valid <= 1'b1;
        r_res_port  <= w_port;
        r_res_hit   <= w_hit;
        r_res_rule  <= w_rule;
      end else if (res_ready_i) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign cfg_rvalid_o = r_cfg_rvalid;
  assign cfg_rdata_o  = r_cfg_rdata;
  assign cfg_error_o  = r_cfg_error;
  assign res_valid_o  = r_res_valid;
  assign res_port_o   = r_res_port;
  assign res_hit_o    = r_res_hit;
  assign res_rule_o   = r_res_rule;

endmodule
